// File: rtl/hw_field_ctrl.sv
// Software/hardware-updated register field with selectable hardware behaviour.
// Hardware can load, set, clear, increment or decrement the field, with an optional overflow lock.

`ifndef HW_RW
`define HW_RW  0
`endif
`ifndef HW_SET
`define HW_SET 1
`endif
`ifndef HW_CLR
`define HW_CLR 2
`endif
`ifndef HW_RO
`define HW_RO  3
`endif
`ifndef HW_INC
`define HW_INC 4
`endif
`ifndef HW_DEC
`define HW_DEC 5
`endif

module hw_field_ctrl #(
    parameter int                 F_WIDTH       = 8,
    parameter int                 N_CH          = 2,
    parameter int                 HW_TYPE       = `HW_RW,
    parameter int                 OVERFLOW_LOCK = 1,
    parameter logic [F_WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_wr_en,
    input  logic [F_WIDTH-1:0]      sw_wr_data,
    input  logic [N_CH-1:0]         hw_pulse,
    input  logic [N_CH*F_WIDTH-1:0] hw_value,
    input  logic                    ovf_clr,
    output logic [F_WIDTH-1:0]      field_value,
    output logic                    hw_modify,
    output logic                    ovf
);

    // The step width holds the sum of every channel's value without loss.
    localparam int SW = F_WIDTH + $clog2(N_CH);
    localparam int PAD = SW + 1 - F_WIDTH;
    localparam logic [SW:0] MAX_EXT = {{PAD{1'b0}}, {F_WIDTH{1'b1}}};
    localparam bit LOCK = (OVERFLOW_LOCK != 0);

    generate
        if (HW_TYPE < `HW_RW || HW_TYPE > `HW_DEC) begin : g_bad_type
            $fatal(1, "hw_field_ctrl: unsupported HW_TYPE %0d", HW_TYPE);
        end
    endgenerate

    logic [F_WIDTH-1:0] or_mask;
    logic [F_WIDTH-1:0] rw_data;
    logic               rw_hit;
    logic [SW-1:0]      step;
    logic [SW:0]        field_ext;
    logic [SW:0]        step_ext;
    logic [SW:0]        sum_ext;
    logic [F_WIDTH-1:0] next_field;
    logic               ovf_event;
    logic               count_blocked;

    always_comb begin
        or_mask = '0;
        rw_data = '0;
        rw_hit  = 1'b0;
        step    = '0;
        for (int i = 0; i < N_CH; i++) begin
            or_mask = or_mask | hw_value[i*F_WIDTH +: F_WIDTH];
            if (hw_pulse[i]) begin
                step = step + SW'(hw_value[i*F_WIDTH +: F_WIDTH]);
                if (!rw_hit) begin
                    rw_data = hw_value[i*F_WIDTH +: F_WIDTH];
                end
                rw_hit = 1'b1;
            end
        end
    end

    assign field_ext     = {{PAD{1'b0}}, field_value};
    assign step_ext      = {1'b0, step};
    assign sum_ext       = field_ext + step_ext;
    assign count_blocked = LOCK && ovf;

    always_comb begin
        next_field = field_value;
        ovf_event  = 1'b0;
        case (HW_TYPE)
            `HW_RW: begin
                if (rw_hit) begin
                    next_field = rw_data;
                end
            end
            `HW_SET: begin
                if (or_mask != '0) begin
                    next_field = field_value | or_mask;
                end
            end
            `HW_CLR: begin
                if (or_mask != '0) begin
                    next_field = field_value & ~or_mask;
                end
            end
            `HW_INC: begin
                if (step != '0 && !count_blocked) begin
                    if (sum_ext > MAX_EXT) begin
                        ovf_event  = 1'b1;
                        next_field = LOCK ? '1 : sum_ext[F_WIDTH-1:0];
                    end else begin
                        next_field = sum_ext[F_WIDTH-1:0];
                    end
                end
            end
            `HW_DEC: begin
                // Modulo-2^F subtraction only needs the low step bits; the full step decides underflow.
                if (step != '0 && !count_blocked) begin
                    if (step_ext > field_ext) begin
                        ovf_event  = 1'b1;
                        next_field = LOCK ? '0 : field_value - step[F_WIDTH-1:0];
                    end else begin
                        next_field = field_value - step[F_WIDTH-1:0];
                    end
                end
            end
            default: begin
                next_field = field_value;
            end
        endcase
    end

    // Software writes override hardware and clear the sticky flag; a new overflow beats ovf_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_value <= RESET_VAL;
            hw_modify   <= 1'b0;
            ovf         <= 1'b0;
        end else if (sw_wr_en) begin
            field_value <= sw_wr_data;
            hw_modify   <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            field_value <= next_field;
            hw_modify   <= (next_field != field_value);
            ovf         <= ovf_event | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_hw_field_ctrl.sv
// Directed self-checking bench for hw_field_ctrl, one instance per hardware mode under test.

`ifndef HW_RW
`define HW_RW  0
`endif
`ifndef HW_SET
`define HW_SET 1
`endif
`ifndef HW_CLR
`define HW_CLR 2
`endif
`ifndef HW_RO
`define HW_RO  3
`endif
`ifndef HW_INC
`define HW_INC 4
`endif
`ifndef HW_DEC
`define HW_DEC 5
`endif

module tb_hw_field_ctrl;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    logic        rw_wr_en, il_wr_en, iw_wr_en, cl_wr_en, dc_wr_en, st_wr_en;
    logic [7:0]  rw_wr_data, il_wr_data, iw_wr_data, cl_wr_data, dc_wr_data, st_wr_data;
    logic [1:0]  rw_pulse, il_pulse, iw_pulse, cl_pulse, dc_pulse, st_pulse;
    logic [15:0] rw_value, il_value, iw_value, cl_value, dc_value, st_value;
    logic        rw_ovf_clr, il_ovf_clr, iw_ovf_clr, cl_ovf_clr, dc_ovf_clr, st_ovf_clr;
    logic [7:0]  rw_field, il_field, iw_field, cl_field, dc_field, st_field;
    logic        rw_mod, il_mod, iw_mod, cl_mod, dc_mod, st_mod;
    logic        rw_ovf, il_ovf, iw_ovf, cl_ovf, dc_ovf, st_ovf;

    hw_field_ctrl #(.F_WIDTH(8), .N_CH(2), .HW_TYPE(`HW_RW), .OVERFLOW_LOCK(1), .RESET_VAL(8'h00)) u_rw (
        .clk(clk), .rst(rst), .sw_wr_en(rw_wr_en), .sw_wr_data(rw_wr_data), .hw_pulse(rw_pulse),
        .hw_value(rw_value), .ovf_clr(rw_ovf_clr), .field_value(rw_field), .hw_modify(rw_mod), .ovf(rw_ovf));

    hw_field_ctrl #(.F_WIDTH(8), .N_CH(2), .HW_TYPE(`HW_INC), .OVERFLOW_LOCK(1), .RESET_VAL(8'h00)) u_inc_lock (
        .clk(clk), .rst(rst), .sw_wr_en(il_wr_en), .sw_wr_data(il_wr_data), .hw_pulse(il_pulse),
        .hw_value(il_value), .ovf_clr(il_ovf_clr), .field_value(il_field), .hw_modify(il_mod), .ovf(il_ovf));

    hw_field_ctrl #(.F_WIDTH(8), .N_CH(2), .HW_TYPE(`HW_INC), .OVERFLOW_LOCK(0), .RESET_VAL(8'h00)) u_inc_wrap (
        .clk(clk), .rst(rst), .sw_wr_en(iw_wr_en), .sw_wr_data(iw_wr_data), .hw_pulse(iw_pulse),
        .hw_value(iw_value), .ovf_clr(iw_ovf_clr), .field_value(iw_field), .hw_modify(iw_mod), .ovf(iw_ovf));

    hw_field_ctrl #(.F_WIDTH(8), .N_CH(2), .HW_TYPE(`HW_CLR), .OVERFLOW_LOCK(1), .RESET_VAL(8'h00)) u_clr (
        .clk(clk), .rst(rst), .sw_wr_en(cl_wr_en), .sw_wr_data(cl_wr_data), .hw_pulse(cl_pulse),
        .hw_value(cl_value), .ovf_clr(cl_ovf_clr), .field_value(cl_field), .hw_modify(cl_mod), .ovf(cl_ovf));

    hw_field_ctrl #(.F_WIDTH(8), .N_CH(2), .HW_TYPE(`HW_DEC), .OVERFLOW_LOCK(1), .RESET_VAL(8'h05)) u_dec (
        .clk(clk), .rst(rst), .sw_wr_en(dc_wr_en), .sw_wr_data(dc_wr_data), .hw_pulse(dc_pulse),
        .hw_value(dc_value), .ovf_clr(dc_ovf_clr), .field_value(dc_field), .hw_modify(dc_mod), .ovf(dc_ovf));

    hw_field_ctrl #(.F_WIDTH(8), .N_CH(2), .HW_TYPE(`HW_SET), .OVERFLOW_LOCK(1), .RESET_VAL(8'h00)) u_set (
        .clk(clk), .rst(rst), .sw_wr_en(st_wr_en), .sw_wr_data(st_wr_data), .hw_pulse(st_pulse),
        .hw_value(st_value), .ovf_clr(st_ovf_clr), .field_value(st_field), .hw_modify(st_mod), .ovf(st_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        {rw_wr_en, il_wr_en, iw_wr_en, cl_wr_en, dc_wr_en, st_wr_en} = '0;
        {rw_wr_data, il_wr_data, iw_wr_data, cl_wr_data, dc_wr_data, st_wr_data} = '0;
        {rw_pulse, il_pulse, iw_pulse, cl_pulse, dc_pulse, st_pulse} = '0;
        {rw_value, il_value, iw_value, cl_value, dc_value, st_value} = '0;
        {rw_ovf_clr, il_ovf_clr, iw_ovf_clr, cl_ovf_clr, dc_ovf_clr, st_ovf_clr} = '0;

        // Reset values appear before any clock edge.
        #3;
        check_output("reset_rw_field", rw_field, 8'h00);
        check_output("reset_rw_mod", rw_mod, 1'b0);
        check_output("reset_il_ovf", il_ovf, 1'b0);
        check_output("reset_dec_field", dc_field, 8'h05);
        @(negedge clk);
        rst = 1'b0;

        // HW_RW: lowest pulsed channel wins.
        rw_pulse = 2'b11;
        rw_value = {8'h22, 8'h11};
        tick();
        check_output("rw_both_field", rw_field, 8'h11);
        check_output("rw_both_mod", rw_mod, 1'b1);
        rw_pulse = 2'b00;
        tick();
        check_output("rw_idle_field", rw_field, 8'h11);
        check_output("rw_idle_mod", rw_mod, 1'b0);
        rw_pulse = 2'b10;
        tick();
        check_output("rw_ch1_field", rw_field, 8'h22);
        rw_pulse = 2'b00;

        // HW_INC, locking.
        il_wr_en = 1'b1;
        il_wr_data = 8'hFE;
        tick();
        check_output("il_wr_field", il_field, 8'hFE);
        check_output("il_wr_mod", il_mod, 1'b0);
        il_wr_en = 1'b0;
        il_pulse = 2'b11;
        il_value = {8'h02, 8'h01};
        tick();
        check_output("il_sat_field", il_field, 8'hFF);
        check_output("il_sat_ovf", il_ovf, 1'b1);
        check_output("il_sat_mod", il_mod, 1'b1);
        tick();
        check_output("il_lock_field", il_field, 8'hFF);
        check_output("il_lock_mod", il_mod, 1'b0);
        check_output("il_lock_ovf", il_ovf, 1'b1);
        il_pulse = 2'b00;
        il_ovf_clr = 1'b1;
        tick();
        check_output("il_clr_ovf", il_ovf, 1'b0);
        il_ovf_clr = 1'b0;
        il_pulse = 2'b01;
        il_value = {8'h00, 8'h01};
        tick();
        check_output("il_resat_field", il_field, 8'hFF);
        check_output("il_resat_ovf", il_ovf, 1'b1);
        check_output("il_resat_mod", il_mod, 1'b0);
        il_pulse = 2'b00;
        il_wr_en = 1'b1;
        il_wr_data = 8'h10;
        tick();
        check_output("il_wr_clears_ovf", il_ovf, 1'b0);
        il_wr_en = 1'b0;
        il_pulse = 2'b11;
        il_value = 16'h0000;
        tick();
        check_output("il_zero_step_field", il_field, 8'h10);
        check_output("il_zero_step_mod", il_mod, 1'b0);
        il_pulse = 2'b01;
        il_value = {8'h00, 8'h05};
        tick();
        check_output("il_add_field", il_field, 8'h15);
        check_output("il_add_mod", il_mod, 1'b1);
        il_pulse = 2'b00;
        il_wr_en = 1'b1;
        il_wr_data = 8'hFE;
        tick();
        il_wr_en = 1'b0;
        il_ovf_clr = 1'b1;
        il_pulse = 2'b01;
        il_value = {8'h00, 8'h03};
        tick();
        check_output("il_set_beats_clr", il_ovf, 1'b1);
        il_ovf_clr = 1'b0;
        il_pulse = 2'b00;

        // HW_INC, wrapping.
        iw_wr_en = 1'b1;
        iw_wr_data = 8'hFE;
        tick();
        iw_wr_en = 1'b0;
        iw_pulse = 2'b01;
        iw_value = {8'h00, 8'h03};
        tick();
        check_output("iw_wrap_field", iw_field, 8'h01);
        check_output("iw_wrap_ovf", iw_ovf, 1'b1);
        iw_value = {8'h00, 8'h01};
        tick();
        check_output("iw_next_field", iw_field, 8'h02);
        check_output("iw_sticky_ovf", iw_ovf, 1'b1);
        iw_ovf_clr = 1'b1;
        iw_value = {8'h00, 8'hFE};
        tick();
        check_output("iw_wrap2_field", iw_field, 8'h00);
        check_output("iw_set_beats_clr", iw_ovf, 1'b1);
        iw_pulse = 2'b00;
        tick();
        check_output("iw_clr_ovf", iw_ovf, 1'b0);
        iw_ovf_clr = 1'b0;

        // HW_CLR with a competing software write.
        cl_wr_en = 1'b1;
        cl_wr_data = 8'hFF;
        tick();
        cl_value = {8'h30, 8'h0F};
        cl_wr_data = 8'hA5;
        tick();
        check_output("cl_sw_wins_field", cl_field, 8'hA5);
        check_output("cl_sw_wins_mod", cl_mod, 1'b0);
        cl_wr_en = 1'b0;
        tick();
        check_output("cl_mask_field", cl_field, 8'h80);
        check_output("cl_mask_mod", cl_mod, 1'b1);
        tick();
        check_output("cl_nochange_mod", cl_mod, 1'b0);
        cl_value = 16'h0000;

        // HW_SET ignores pulses and flags only real changes.
        st_wr_en = 1'b1;
        st_wr_data = 8'h0F;
        tick();
        st_wr_en = 1'b0;
        st_value = {8'h00, 8'h03};
        tick();
        check_output("st_noop_field", st_field, 8'h0F);
        check_output("st_noop_mod", st_mod, 1'b0);
        st_value = {8'h80, 8'h10};
        tick();
        check_output("st_or_field", st_field, 8'h9F);
        check_output("st_or_mod", st_mod, 1'b1);
        st_value = 16'h0000;

        // HW_DEC with reset landing on a pending update.
        dc_pulse = 2'b01;
        dc_value = {8'h00, 8'h02};
        tick();
        check_output("dc_sub_field", dc_field, 8'h03);
        check_output("dc_sub_mod", dc_mod, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_output("dc_async_rst_field", dc_field, 8'h05);
        check_output("dc_async_rst_mod", dc_mod, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dc_value = {8'h00, 8'h07};
        tick();
        check_output("dc_under_field", dc_field, 8'h00);
        check_output("dc_under_ovf", dc_ovf, 1'b1);
        dc_value = {8'h00, 8'h01};
        tick();
        check_output("dc_lock_field", dc_field, 8'h00);
        check_output("dc_lock_mod", dc_mod, 1'b0);
        dc_pulse = 2'b00;
        dc_wr_en = 1'b1;
        dc_wr_data = 8'h09;
        tick();
        check_output("dc_wr_field", dc_field, 8'h09);
        check_output("dc_wr_ovf", dc_ovf, 1'b0);
        dc_wr_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hw_field_ctrl.md
HW_FIELD_CTRL -- requirements
Module: hw_field_ctrl

Interface
REQ-001 The block SHALL have parameter F_WIDTH, default 8, giving the field width in bits (1..32).
REQ-002 The block SHALL have parameter N_CH, default 2, giving the number of hardware update channels (1..8).
REQ-003 The block SHALL have parameter HW_TYPE, default `HW_RW, selecting the mode: `HW_RW, `HW_SET, `HW_CLR, `HW_RO, `HW_INC or `HW_DEC.
REQ-004 The block SHALL have parameter OVERFLOW_LOCK, default 1: 1 saturates and locks on overflow; 0 wraps.
REQ-005 The block SHALL have parameter RESET_VAL, default 0, giving the field reset value (F_WIDTH bits).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port sw_wr_en, input, 1 bit: software write strobe.
REQ-009 The block SHALL have port sw_wr_data, input, F_WIDTH bits: software write data.
REQ-010 The block SHALL have port hw_pulse, input, N_CH bits: per-channel hardware strobe.
REQ-011 The block SHALL have port hw_value, input, N_CH*F_WIDTH bits: per-channel data or mask; channel i occupies bits [i*F_WIDTH +: F_WIDTH].
REQ-012 The block SHALL have port ovf_clr, input, 1 bit: clears the overflow/underflow flag.
REQ-013 The block SHALL have port field_value, output, F_WIDTH bits: registered field content.
REQ-014 The block SHALL have port hw_modify, output, 1 bit: registered strobe, high for the one cycle following any hardware-caused change.
REQ-015 The block SHALL have port ovf, output, 1 bit: sticky overflow (INC) or underflow (DEC) flag.

Function
REQ-016 In HW_RW, the lowest-index channel with hw_pulse set SHALL load its hw_value; other channels are ignored.
REQ-017 In HW_SET, next = field | OR of hw_value over all channels, applied when that OR is nonzero; hw_pulse SHALL be ignored.
REQ-018 In HW_CLR, next = field & ~(OR of hw_value over all channels), applied when that OR is nonzero; hw_pulse SHALL be ignored.
REQ-019 In HW_RO, hardware inputs SHALL have no effect; only software writes change the field.
REQ-020 In HW_INC/HW_DEC, the step SHALL be the sum of hw_value over channels whose hw_pulse is set, computed at width F_WIDTH+clog2(N_CH) with no truncation; the field is then increased (INC) or decreased (DEC) by the step.
REQ-021 In INC with OVERFLOW_LOCK=1, when field+step exceeds 2^F_WIDTH-1, the field SHALL become all-ones and ovf SHALL set.
REQ-022 In DEC with OVERFLOW_LOCK=1, when step exceeds field, the field SHALL become 0 and ovf SHALL set.
REQ-023 With OVERFLOW_LOCK=1 and ovf=1, further INC/DEC updates SHALL be ignored (field held) until ovf_clr or a software write.
REQ-024 With OVERFLOW_LOCK=0, the result SHALL wrap modulo 2^F_WIDTH, ovf SHALL set, and counting continues.
REQ-025 A software write SHALL take priority over all hardware updates in the same cycle: field <= sw_wr_data, hw_modify=0 next cycle, and ovf cleared.
REQ-026 ovf_clr SHALL clear ovf next cycle; if a new overflow occurs in the same cycle, ovf SHALL remain 1 (set wins over clear).
REQ-027 hw_modify SHALL be 1 in cycle t+1 only if a hardware update in cycle t changed field_value; an update with no net change (e.g. SET of bits already set, locked counter) SHALL give hw_modify=0.
REQ-028 Update latency SHALL be one cycle: inputs sampled at edge t appear on field_value after edge t.
REQ-029 A zero step in INC/DEC (pulses set but hw_value zero) SHALL leave the field and ovf unchanged.
REQ-030 An unsupported HW_TYPE SHALL cause a simulation-time message and $finish; it SHALL produce no synthesised logic.

Reset
REQ-031 While rst=1, outputs SHALL be forced immediately, without waiting for a clock: field_value=RESET_VAL, hw_modify=0, ovf=0.
REQ-032 Reset asserted mid-operation SHALL abandon any pending update; the first update after rst deasserts SHALL take effect on the first subsequent rising edge.

Verification
REQ-033 HW_RW, N_CH=2, F_WIDTH=8: both pulses set, ch0=0x11, ch1=0x22 -> field_value=0x11 next cycle and hw_modify=1 for one cycle.
REQ-034 HW_INC, OVERFLOW_LOCK=1, field=0xFE: ch0 pulse value 1 plus ch1 pulse value 2 -> field=0xFF and ovf=1; a further increment -> field stays 0xFF with hw_modify=0; then ovf_clr followed by an increment -> field remains 0xFF (saturated), ovf=1 again.
REQ-035 HW_INC, OVERFLOW_LOCK=0, field=0xFE, step 3 -> field=0x01, ovf=1; next step 1 -> field=0x02.
REQ-036 HW_CLR, field=0xFF: ch0=0x0F, ch1=0x30, with a simultaneous sw_wr_en and data 0xA5 -> field=0xA5, hw_modify=0; in the next cycle the same masks with no write -> field=0x80, hw_modify=1.
REQ-037 HW_DEC, RESET_VAL=0x05: rst pulsed while an update is pending -> field=0x05 immediately; after release, step 7 -> field=0x00, ovf=1.
REQ-038 HW_SET, field=0x0F: mask 0x03 -> field unchanged and hw_modify=0; ovf_clr and an overflow in the same cycle (INC build) -> ovf=1.
